// File: rtl/db_fe_pkg.sv
// rtl/db_fe_pkg.sv - shared constants for the DB frontend core
// Register offsets within a channel's 8-word settings window, MUX control
// bit positions, and the per-channel address strides.
package db_fe_pkg;

    localparam logic [2:0] K_RX_OFS_I   = 3'd0;
    localparam logic [2:0] K_RX_OFS_Q   = 3'd1;
    localparam logic [2:0] K_TX_OFS_I   = 3'd2;
    localparam logic [2:0] K_TX_OFS_Q   = 3'd3;
    localparam logic [2:0] K_MUX        = 3'd4;
    localparam logic [2:0] K_APPLY_MODE = 3'd5;
    localparam logic [2:0] K_CLR_SAT    = 3'd6;

    localparam int MUX_RX_SWAP = 0;
    localparam int MUX_RX_NEG  = 1;
    localparam int MUX_TX_SWAP = 2;
    localparam int MUX_RX_REAL = 3;

    localparam int SR_STRIDE = 8;
    localparam int RB_STRIDE = 2;

endpackage

// File: rtl/db_fe_chan.sv
// rtl/db_fe_chan.sv - one TX/RX frontend channel
// Ports: clk/reset; wr_en/wr_k/wr_data decoded settings write; time_sync
// timed-apply pulse; tx_*/rx_* sample strobes, run flags and I/Q data
// (I in upper half); rb_word0 config readback, rb_word1 {tx_sat, rx_sat}.
module db_fe_chan
    import db_fe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [2:0]           wr_k,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 time_sync,
    input  logic                 tx_stb,
    input  logic                 tx_running,
    input  logic [2*WIDTH-1:0]   tx_data_in,
    input  logic                 rx_stb_in,
    input  logic                 rx_running,
    input  logic [2*WIDTH-1:0]   rx_data_in,
    output logic                 tx_stb_out,
    output logic [2*WIDTH-1:0]   tx_data_out,
    output logic                 rx_stb_out,
    output logic [2*WIDTH-1:0]   rx_data_out,
    output logic [63:0]          rb_word0,
    output logic [63:0]          rb_word1
);

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] x);
        return (x == S_MIN) ? S_MAX : -x;
    endfunction

    // Returns {clip, saturated a+b}.
    function automatic logic [WIDTH:0] add_sat(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            return {1'b1, (s[WIDTH] ? S_MIN : S_MAX)};
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    logic [WIDTH-1:0]   sh_ofs_q [4];
    logic [WIDTH-1:0]   sh_ofs_d [4];
    logic [WIDTH-1:0]   act_ofs_q[4];
    logic [WIDTH-1:0]   act_ofs_d[4];
    logic [3:0]         sh_mux_q, sh_mux_d, act_mux_q, act_mux_d;
    logic               apply_mode_q, apply_mode_d, sync_q, sync_d;
    logic               rx_s1_stb_q, rx_s1_stb_d, tx_s1_stb_q, tx_s1_stb_d;
    logic [2*WIDTH-1:0] rx_s1_q, rx_s1_d, tx_s1_q, tx_s1_d;
    logic               rx_o_stb_q, rx_o_stb_d, tx_o_stb_q, tx_o_stb_d;
    logic [2*WIDTH-1:0] rx_o_q, rx_o_d, tx_o_q, tx_o_d;
    logic [31:0]        rx_sat_q, rx_sat_d, tx_sat_q, tx_sat_d;

    logic [WIDTH-1:0]   rx_q_neg;
    logic [2*WIDTH-1:0] rx_shaped, tx_shaped;
    logic [WIDTH:0]     rx_sum_i, rx_sum_q, tx_sum_i, tx_sum_q;
    logic               rx_clip, tx_clip, clr_sat;

    always_comb begin
        sh_ofs_d     = sh_ofs_q;
        sh_mux_d     = sh_mux_q;
        apply_mode_d = apply_mode_q;
        if (wr_en) begin
            case (wr_k)
                K_RX_OFS_I, K_RX_OFS_Q, K_TX_OFS_I, K_TX_OFS_Q:
                    sh_ofs_d[wr_k[1:0]] = wr_data;
                K_MUX:        sh_mux_d     = wr_data[3:0];
                K_APPLY_MODE: apply_mode_d = wr_data[0];
                default: ;
            endcase
        end
        clr_sat = wr_en && (wr_k == K_CLR_SAT);

        // Copy from the registered shadow one cycle after it lands; a write
        // coinciding with time_sync is therefore already in the shadow.
        sync_d = time_sync;
        if (!apply_mode_q || sync_q) begin
            act_ofs_d = sh_ofs_q;
            act_mux_d = sh_mux_q;
        end else begin
            act_ofs_d = act_ofs_q;
            act_mux_d = act_mux_q;
        end

        // Stage 1: Q is negated before the swap, real mode zeroes the final Q.
        rx_q_neg  = act_mux_q[MUX_RX_NEG] ? neg_sat(rx_data_in[WIDTH-1:0])
                                          : rx_data_in[WIDTH-1:0];
        rx_shaped = act_mux_q[MUX_RX_SWAP] ? {rx_q_neg, rx_data_in[2*WIDTH-1:WIDTH]}
                                           : {rx_data_in[2*WIDTH-1:WIDTH], rx_q_neg};
        if (act_mux_q[MUX_RX_REAL])
            rx_shaped[WIDTH-1:0] = '0;
        tx_shaped = act_mux_q[MUX_TX_SWAP] ? {tx_data_in[WIDTH-1:0], tx_data_in[2*WIDTH-1:WIDTH]}
                                           : tx_data_in;
        rx_s1_stb_d = rx_stb_in;
        rx_s1_d     = rx_stb_in ? rx_shaped : rx_s1_q;
        tx_s1_stb_d = tx_stb;
        tx_s1_d     = tx_stb ? tx_shaped : tx_s1_q;

        // Stage 2: offset add with saturation; clip counts only offset clipping.
        rx_sum_i = add_sat(rx_s1_q[2*WIDTH-1:WIDTH], act_ofs_q[K_RX_OFS_I[1:0]]);
        rx_sum_q = add_sat(rx_s1_q[WIDTH-1:0],       act_ofs_q[K_RX_OFS_Q[1:0]]);
        tx_sum_i = add_sat(tx_s1_q[2*WIDTH-1:WIDTH], act_ofs_q[K_TX_OFS_I[1:0]]);
        tx_sum_q = add_sat(tx_s1_q[WIDTH-1:0],       act_ofs_q[K_TX_OFS_Q[1:0]]);
        rx_o_stb_d = rx_s1_stb_q;
        rx_o_d     = rx_s1_stb_q ? {rx_sum_i[WIDTH-1:0], rx_sum_q[WIDTH-1:0]} : rx_o_q;
        tx_o_stb_d = tx_s1_stb_q;
        tx_o_d     = tx_s1_stb_q ? {tx_sum_i[WIDTH-1:0], tx_sum_q[WIDTH-1:0]} : tx_o_q;
        rx_clip    = rx_s1_stb_q && (rx_sum_i[WIDTH] || rx_sum_q[WIDTH]);
        tx_clip    = tx_s1_stb_q && (tx_sum_i[WIDTH] || tx_sum_q[WIDTH]);

        rx_sat_d = rx_sat_q;
        if (rx_clip && rx_sat_q != '1)
            rx_sat_d = rx_sat_q + 32'd1;
        tx_sat_d = tx_sat_q;
        if (tx_clip && tx_sat_q != '1)
            tx_sat_d = tx_sat_q + 32'd1;
        if (clr_sat) begin
            rx_sat_d = '0;
            tx_sat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ofs_q     <= '{default: '0};
            act_ofs_q    <= '{default: '0};
            sh_mux_q     <= '0;
            act_mux_q    <= '0;
            apply_mode_q <= 1'b0;
            sync_q       <= 1'b0;
            rx_s1_stb_q  <= 1'b0;
            tx_s1_stb_q  <= 1'b0;
            rx_s1_q      <= '0;
            tx_s1_q      <= '0;
            rx_o_stb_q   <= 1'b0;
            tx_o_stb_q   <= 1'b0;
            rx_o_q       <= '0;
            tx_o_q       <= '0;
            rx_sat_q     <= '0;
            tx_sat_q     <= '0;
        end else begin
            sh_ofs_q     <= sh_ofs_d;
            act_ofs_q    <= act_ofs_d;
            sh_mux_q     <= sh_mux_d;
            act_mux_q    <= act_mux_d;
            apply_mode_q <= apply_mode_d;
            sync_q       <= sync_d;
            rx_s1_stb_q  <= rx_s1_stb_d;
            tx_s1_stb_q  <= tx_s1_stb_d;
            rx_s1_q      <= rx_s1_d;
            tx_s1_q      <= tx_s1_d;
            rx_o_stb_q   <= rx_o_stb_d;
            tx_o_stb_q   <= tx_o_stb_d;
            rx_o_q       <= rx_o_d;
            tx_o_q       <= tx_o_d;
            rx_sat_q     <= rx_sat_d;
            tx_sat_q     <= tx_sat_d;
        end
    end

    assign rx_stb_out  = rx_o_stb_q && rx_running;
    assign rx_data_out = rx_running ? rx_o_q : '0;
    assign tx_stb_out  = tx_o_stb_q && tx_running;
    assign tx_data_out = tx_running ? tx_o_q : '0;

    // Fields packed from bit 0 upward; anything past bit 63 is dropped.
    assign rb_word0 = 64'({act_ofs_q[3], act_ofs_q[2], act_ofs_q[1], act_ofs_q[0],
                           apply_mode_q, act_mux_q});
    assign rb_word1 = {tx_sat_q, rx_sat_q};

endmodule

// File: rtl/db_fe_core_mc.sv
// rtl/db_fe_core_mc.sv - multi-channel TX/RX frontend correction core
// Ports: clk/reset; set_stb/set_addr/set_data settings writes; rb_addr in,
// rb_stb/rb_data registered readback; time_sync timed apply; per-channel
// tx/rx strobes, run flags and packed I/Q data in and out.
module db_fe_core_mc
    import db_fe_pkg::*;
#(
    parameter int         NUM_CHANS = 2,
    parameter int         WIDTH     = 16,
    parameter logic [7:0] SR_BASE   = 8'd160,
    parameter logic [7:0] RB_BASE   = 8'd16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set_stb,
    input  logic [7:0]                     set_addr,
    input  logic [31:0]                    set_data,
    input  logic [7:0]                     rb_addr,
    output logic                           rb_stb,
    output logic [63:0]                    rb_data,
    input  logic                           time_sync,
    input  logic [NUM_CHANS-1:0]           tx_stb,
    input  logic [NUM_CHANS-1:0]           tx_running,
    input  logic [NUM_CHANS-1:0]           rx_stb_in,
    input  logic [NUM_CHANS-1:0]           rx_running,
    input  logic [NUM_CHANS*2*WIDTH-1:0]   tx_data_in,
    input  logic [NUM_CHANS*2*WIDTH-1:0]   rx_data_in,
    output logic [NUM_CHANS-1:0]           tx_stb_out,
    output logic [NUM_CHANS-1:0]           rx_stb_out,
    output logic [NUM_CHANS*2*WIDTH-1:0]   tx_data_out,
    output logic [NUM_CHANS*2*WIDTH-1:0]   rx_data_out
);

    // Offsets wrap modulo 256, so addresses below the base land out of range.
    logic [7:0]           set_off, rb_off;
    logic                 set_hit;
    logic [NUM_CHANS-1:0] chan_wr;
    logic [63:0]          word0[NUM_CHANS];
    logic [63:0]          word1[NUM_CHANS];
    logic                 rb_stb_q, rb_stb_d;
    logic [63:0]          rb_data_q, rb_data_d;
    logic                 unused_set_data;

    assign set_off         = set_addr - SR_BASE;
    assign rb_off          = rb_addr - RB_BASE;
    assign set_hit         = set_stb && (int'(set_off) < SR_STRIDE * NUM_CHANS);
    assign unused_set_data = ^set_data;

    for (genvar c = 0; c < NUM_CHANS; c++) begin : g_chan
        assign chan_wr[c] = set_hit && ((int'(set_off) / SR_STRIDE) == c);

        db_fe_chan #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (chan_wr[c]),
            .wr_k       (set_off[2:0]),
            .wr_data    (set_data[WIDTH-1:0]),
            .time_sync  (time_sync),
            .tx_stb     (tx_stb[c]),
            .tx_running (tx_running[c]),
            .tx_data_in (tx_data_in[2*WIDTH*c +: 2*WIDTH]),
            .rx_stb_in  (rx_stb_in[c]),
            .rx_running (rx_running[c]),
            .rx_data_in (rx_data_in[2*WIDTH*c +: 2*WIDTH]),
            .tx_stb_out (tx_stb_out[c]),
            .tx_data_out(tx_data_out[2*WIDTH*c +: 2*WIDTH]),
            .rx_stb_out (rx_stb_out[c]),
            .rx_data_out(rx_data_out[2*WIDTH*c +: 2*WIDTH]),
            .rb_word0   (word0[c]),
            .rb_word1   (word1[c])
        );
    end

    always_comb begin
        rb_stb_d  = 1'b0;
        rb_data_d = '0;
        for (int c = 0; c < NUM_CHANS; c++) begin
            if (int'(rb_off) == RB_STRIDE * c) begin
                rb_stb_d  = 1'b1;
                rb_data_d = word0[c];
            end
            if (int'(rb_off) == RB_STRIDE * c + 1) begin
                rb_stb_d  = 1'b1;
                rb_data_d = word1[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_stb_q  <= 1'b0;
            rb_data_q <= '0;
        end else begin
            rb_stb_q  <= rb_stb_d;
            rb_data_q <= rb_data_d;
        end
    end

    assign rb_stb  = rb_stb_q;
    assign rb_data = rb_data_q;

endmodule

// File: tb/tb_db_fe_core_mc.sv
// tb/tb_db_fe_core_mc.sv - self-checking bench for db_fe_core_mc
module tb_db_fe_core_mc;

    localparam int         N  = 2;
    localparam int         W  = 16;
    localparam logic [7:0] SR = 8'd160;
    localparam logic [7:0] RB = 8'd16;

    logic            clk = 1'b0;
    logic            reset;
    logic            set_stb;
    logic [7:0]      set_addr;
    logic [31:0]     set_data;
    logic [7:0]      rb_addr;
    logic            rb_stb;
    logic [63:0]     rb_data;
    logic            time_sync;
    logic [N-1:0]    tx_stb, tx_running, rx_stb_in, rx_running;
    logic [N*2*W-1:0] tx_data_in, rx_data_in;
    logic [N-1:0]    tx_stb_out, rx_stb_out;
    logic [N*2*W-1:0] tx_data_out, rx_data_out;

    always #5 clk = ~clk;

    db_fe_core_mc #(.NUM_CHANS(N), .WIDTH(W), .SR_BASE(SR), .RB_BASE(RB)) dut (
        .clk(clk), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rb_addr(rb_addr), .rb_stb(rb_stb), .rb_data(rb_data),
        .time_sync(time_sync),
        .tx_stb(tx_stb), .tx_running(tx_running),
        .rx_stb_in(rx_stb_in), .rx_running(rx_running),
        .tx_data_in(tx_data_in), .rx_data_in(rx_data_in),
        .tx_stb_out(tx_stb_out), .rx_stb_out(rx_stb_out),
        .tx_data_out(tx_data_out), .rx_data_out(rx_data_out)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Direction index: 0 = RX, 1 = TX.
    logic [15:0] m_sh[N][4];
    logic [15:0] m_act[N][4];
    logic [3:0]  m_shmux[N], m_actmux[N];
    logic        m_mode[N];
    logic        m_sync;
    logic        m_pv[N][2];
    logic [31:0] m_pd[N][2];
    logic        m_ostb[N][2];
    logic [31:0] m_od[N][2];
    logic [31:0] m_cnt[N][2];
    logic        m_rbs;
    logic [63:0] m_rbd;

    function automatic logic [15:0] clamp(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic logic [31:0] shape(input logic [31:0] x, input logic [3:0] mux, input bit tx);
        int i, q, t;
        i = $signed(x[31:16]);
        q = $signed(x[15:0]);
        if (tx) begin
            if (mux[2]) begin t = i; i = q; q = t; end
        end else begin
            if (mux[1]) q = -q;
            if (mux[0]) begin t = i; i = q; q = t; end
            if (mux[3]) q = 0;
        end
        return {clamp(i), clamp(q)};
    endfunction

    function automatic logic [32:0] offs(input logic [31:0] x, input logic [15:0] oi, input logic [15:0] oq);
        int si, sq;
        bit clip;
        si   = $signed(x[31:16]) + $signed(oi);
        sq   = $signed(x[15:0]) + $signed(oq);
        clip = (si > 32767) || (si < -32768) || (sq > 32767) || (sq < -32768);
        return {clip, clamp(si), clamp(sq)};
    endfunction

    logic [7:0]  so, ro;
    int          wc, wk;
    logic [32:0] r;
    logic        sin;
    logic [31:0] din;

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                for (int k = 0; k < 4; k++) begin m_sh[c][k] = '0; m_act[c][k] = '0; end
                m_shmux[c] = '0; m_actmux[c] = '0; m_mode[c] = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    m_pv[c][d] = 1'b0; m_pd[c][d] = '0; m_ostb[c][d] = 1'b0;
                    m_od[c][d] = '0;   m_cnt[c][d] = '0;
                end
            end
            m_sync = 1'b0; m_rbs = 1'b0; m_rbd = '0;
        end else begin
            ro    = rb_addr - RB;
            m_rbs = (int'(ro) < 2 * N);
            m_rbd = '0;
            if (m_rbs) begin
                wc = int'(ro) / 2;
                if (ro[0]) m_rbd = {m_cnt[wc][1], m_cnt[wc][0]};
                else m_rbd = 64'(m_actmux[wc]) | (64'(m_mode[wc]) << 4) |
                             (64'(m_act[wc][0]) << 5)  | (64'(m_act[wc][1]) << 21) |
                             (64'(m_act[wc][2]) << 37) | (64'(m_act[wc][3]) << 53);
            end
            for (int c = 0; c < N; c++) begin
                for (int d = 0; d < 2; d++) begin
                    // A sample captured last edge gets the offsets active now.
                    if (m_pv[c][d]) begin
                        r = offs(m_pd[c][d], m_act[c][2*d], m_act[c][2*d+1]);
                        m_ostb[c][d] = 1'b1;
                        m_od[c][d]   = r[31:0];
                        if (r[32] && m_cnt[c][d] != 32'hFFFF_FFFF) m_cnt[c][d]++;
                    end else begin
                        m_ostb[c][d] = 1'b0;
                    end
                    sin = d ? tx_stb[c] : rx_stb_in[c];
                    din = d ? tx_data_in[c*32 +: 32] : rx_data_in[c*32 +: 32];
                    m_pv[c][d] = sin;
                    if (sin) m_pd[c][d] = shape(din, m_actmux[c], d != 0);
                end
            end
            so = set_addr - SR;
            wc = int'(so) / 8;
            wk = int'(so) % 8;
            if (set_stb && int'(so) < 8 * N && wk == 6) begin
                m_cnt[wc][0] = '0; m_cnt[wc][1] = '0;
            end
            for (int c = 0; c < N; c++) begin
                if (!m_mode[c] || m_sync) begin
                    for (int k = 0; k < 4; k++) m_act[c][k] = m_sh[c][k];
                    m_actmux[c] = m_shmux[c];
                end
            end
            m_sync = time_sync;
            if (set_stb && int'(so) < 8 * N) begin
                if (wk < 4)       m_sh[wc][wk] = set_data[15:0];
                else if (wk == 4) m_shmux[wc]  = set_data[3:0];
                else if (wk == 5) m_mode[wc]   = set_data[0];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("rx_stb_out[%0d]", c), 64'(rx_stb_out[c]), 64'(m_ostb[c][0] & rx_running[c]));
                chk($sformatf("rx_data_out[%0d]", c), 64'(rx_data_out[c*32 +: 32]),
                    rx_running[c] ? 64'(m_od[c][0]) : 64'd0);
                chk($sformatf("tx_stb_out[%0d]", c), 64'(tx_stb_out[c]), 64'(m_ostb[c][1] & tx_running[c]));
                chk($sformatf("tx_data_out[%0d]", c), 64'(tx_data_out[c*32 +: 32]),
                    tx_running[c] ? 64'(m_od[c][1]) : 64'd0);
            end
            chk("rb_stb", 64'(rb_stb), 64'(m_rbs));
            chk("rb_data", rb_data, m_rbd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick();
        set_stb = 1'b0;
    endtask

    task automatic rx_sample(input int c, input logic [31:0] v);
        rx_stb_in[c] = 1'b1;
        rx_data_in[c*32 +: 32] = v;
        tick();
        rx_stb_in[c] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0; rb_addr = '0;
        time_sync = 1'b0; tx_stb = '0; rx_stb_in = '0; tx_running = '0; rx_running = '0;
        tx_data_in = '0; rx_data_in = '0;
        @(negedge clk); #1;
        tick(); tick();
        cmp_en = 1'b1;
        chk("reset_rb_stb", 64'(rb_stb), 64'd0);
        chk("reset_rx_stb", 64'(rx_stb_out), 64'd0);
        chk("reset_tx_data", 64'(tx_data_out), 64'd0);
        reset = 1'b0; rx_running = '1; tx_running = '1;
        tick();

        // Offset saturation on ch1
        wr(SR + 8'd8, 32'h7000); tick();
        rx_sample(1, 32'h2000_0000); tick();
        chk("ofs_sat_stb", 64'(rx_stb_out[1]), 64'd1);
        chk("ofs_sat_i", 64'(rx_data_out[63:48]), 64'h7FFF);
        chk("ofs_sat_q", 64'(rx_data_out[47:32]), 64'h0000);
        rb_addr = RB + 8'd3; tick();
        chk("sat_cnt_1_stb", 64'(rb_stb), 64'd1);
        chk("sat_cnt_1", 64'(rb_data[31:0]), 64'd1);

        // Five clipped samples, then clear
        repeat (4) rx_sample(1, 32'h2000_0000);
        tick(); tick();
        chk("sat_cnt_5", 64'(rb_data[31:0]), 64'd5);
        wr(SR + 8'd14, 32'd0); tick();
        chk("sat_cnt_clr", 64'(rb_data[31:0]), 64'd0);
        rb_addr = RB + 8'd4; tick();
        chk("rb_oor_stb", 64'(rb_stb), 64'd0);
        chk("rb_oor_data", rb_data, 64'd0);

        // Negate-then-swap on ch0
        wr(SR + 8'd4, 32'h3); tick();
        rx_sample(0, 32'h0005_8000); tick();
        chk("mux_neg_swap", 64'(rx_data_out[31:0]), 64'h7FFF_0005);
        wr(SR + 8'd4, 32'h0); tick();

        // Timed apply of TX_OFS_Q on ch0
        wr(SR + 8'd5, 32'h1);
        tx_stb[0] = 1'b1; tx_data_in[31:0] = '0;
        wr(SR + 8'd3, 32'h10);
        repeat (4) tick();
        chk("timed_hold", 64'(tx_data_out[15:0]), 64'h0);
        time_sync = 1'b1; tick(); time_sync = 1'b0;
        tick();
        chk("timed_pre", 64'(tx_data_out[15:0]), 64'h0);
        tick();
        chk("timed_apply", 64'(tx_data_out[15:0]), 64'h0010);
        tx_stb[0] = 1'b0;
        wr(SR + 8'd5, 32'h0); wr(SR + 8'd3, 32'h0); tick(); tick();

        // Run gating
        rx_stb_in = '1; rx_data_in = {32'h1111_2222, 32'h3333_4444};
        rx_running[0] = 1'b0;
        tick(); tick();
        chk("gate_stb", 64'(rx_stb_out[0]), 64'd0);
        chk("gate_data", 64'(rx_data_out[31:0]), 64'd0);
        rx_running = '1;

        // Reset mid-burst
        wr(SR + 8'd0, 32'h0100);
        tx_stb = '1; rb_addr = RB; tick();
        reset = 1'b1; tick();
        chk("rst_rx_stb", 64'(rx_stb_out), 64'd0);
        chk("rst_tx_stb", 64'(tx_stb_out), 64'd0);
        chk("rst_rx_data", 64'(rx_data_out), 64'd0);
        chk("rst_rb_data", rb_data, 64'd0);
        reset = 1'b0; rx_stb_in = '0; tx_stb = '0;
        tick();
        chk("post_rst_1", 64'({rx_stb_out, tx_stb_out}), 64'd0);
        tick();
        chk("post_rst_2", 64'({rx_stb_out, tx_stb_out}), 64'd0);
        chk("passthru_regs", rb_data, 64'd0);
        rx_sample(0, 32'h1234_5678); tick();
        chk("passthru_data", 64'(rx_data_out[31:0]), 64'h1234_5678);

        // Randomised traffic
        repeat (3000) begin
            reset     = ($urandom_range(0, 299) == 0);
            set_stb   = ($urandom_range(0, 3) == 0);
            set_addr  = 8'(158 + $urandom_range(0, 19));
            set_data  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
            time_sync = ($urandom_range(0, 7) == 0);
            rx_stb_in = N'($urandom);
            tx_stb    = N'($urandom);
            for (int c = 0; c < N; c++) begin
                rx_running[c] = ($urandom_range(0, 7) != 0);
                tx_running[c] = ($urandom_range(0, 7) != 0);
            end
            rx_data_in = {$urandom, $urandom};
            tx_data_in = {$urandom, $urandom};
            rb_addr    = 8'(15 + $urandom_range(0, 5));
            tick();
        end
        reset = 1'b0; set_stb = 1'b0; time_sync = 1'b0; rx_stb_in = '0; tx_stb = '0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/db_fe_core_mc.md
DB_FE_CORE_MC -- requirements
Module: db_fe_core_mc

Interface
REQ-001 Parameter NUM_CHANS, default 2: number of independent TX/RX frontend channels, legal range 1..4.
REQ-002 Parameter WIDTH, default 16: per-component I/Q sample width, signed two's complement.
REQ-003 Parameter SR_BASE, default 8'd160: first settings address; channel c occupies SR_BASE+8*c .. SR_BASE+8*c+7.
REQ-004 Parameter RB_BASE, default 8'd16: first readback address; channel c occupies RB_BASE+2*c and RB_BASE+2*c+1.
REQ-005 clk  in  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 set_stb / set_addr / set_data  in  1/8/32  settings bus write.
REQ-008 rb_addr  in  8  readback address.
REQ-009 rb_stb / rb_data  out  1/64  readback valid flag and registered readback word.
REQ-010 time_sync  in  1  single-cycle timed-apply pulse.
REQ-011 tx_stb, tx_running, rx_stb_in, rx_running  in  NUM_CHANS each  per-channel sample strobes and run flags.
REQ-012 tx_data_in, rx_data_in  in  NUM_CHANS*2*WIDTH each  channel c at bits [2*WIDTH*(c+1)-1 : 2*WIDTH*c], I in the upper half.
REQ-013 tx_stb_out, rx_stb_out  out  NUM_CHANS each; tx_data_out, rx_data_out  out  NUM_CHANS*2*WIDTH each.

Function
REQ-014 Per-channel register offsets: k0 RX_OFS_I, k1 RX_OFS_Q, k2 TX_OFS_I, k3 TX_OFS_Q, k4 MUX, k5 APPLY_MODE, k6 CLR_SAT. Offsets use set_data[WIDTH-1:0]; MUX uses bits [3:0]; APPLY_MODE uses bit 0.
REQ-015 MUX bits: bit0 swaps RX I/Q; bit1 negates RX Q, saturating -2^(WIDTH-1) to 2^(WIDTH-1)-1; bit2 swaps TX I/Q; bit3 forces RX Q to 0 (real mode).
REQ-016 Writes to k0..k4 SHALL land in shadow registers on the cycle after set_stb.
REQ-017 When APPLY_MODE=0, the active registers SHALL copy the shadow registers one cycle after the shadow update.
REQ-018 When APPLY_MODE=1, the active registers SHALL copy all shadows atomically on the cycle after time_sync=1.
REQ-019 When a shadow write and time_sync coincide, the copy SHALL use the newly written value.
REQ-020 APPLY_MODE itself takes effect immediately.
REQ-021 Datapath per channel is a 2-stage pipeline (latency 2 cycles, strobe-qualified):
- stage 1: registers the swap, negate and real-mode result;
- stage 2: adds the active offset in WIDTH+1 bits, then saturates to WIDTH.
REQ-022 A sample SHALL advance only when its input strobe is high.
REQ-023 Output strobes SHALL equal the input strobes delayed 2 cycles.
REQ-024 While rx_running[c]=0, rx_stb_out[c] SHALL be 0 and rx_data_out for channel c SHALL be 0. The same rule applies to tx_running and the TX outputs.
REQ-025 Each channel keeps two 32-bit saturation counters, TX and RX.
REQ-026 A saturation counter SHALL increment once per output sample in which I or Q clipped.
REQ-027 A saturation counter SHALL stick at 32'hFFFF_FFFF.
REQ-028 A write to k6 SHALL clear both counters of that channel; a clear and an increment in the same cycle SHALL leave the counter at 0.
REQ-029 Readback at RB_BASE+2c SHALL return {active MUX, APPLY_MODE, active RX_OFS_I, RX_OFS_Q, TX_OFS_I, TX_OFS_Q}, zero-extended and packed LSB-first into 64 bits.
REQ-030 Readback at RB_BASE+2c+1 SHALL return {TX sat count, RX sat count}.
REQ-031 rb_data SHALL be registered with 1-cycle latency from rb_addr.
REQ-032 rb_stb SHALL be 1 exactly when the previous-cycle rb_addr was inside the block's range; otherwise rb_stb=0 and rb_data=0.
REQ-033 Writes to addresses outside the block's range, or to k7, SHALL be ignored.

Reset
REQ-034 On reset, all shadow, active, APPLY_MODE and counter registers SHALL clear to 0, giving pass-through with no offset.
REQ-035 On reset, all pipeline stages, output strobes, output data, rb_stb and rb_data SHALL be 0.
REQ-036 Reset asserted mid-stream SHALL discard in-flight samples; no output strobe SHALL fire during reset or in the 2 cycles after its release until new input strobes arrive.

Structure
REQ-037 A shared package db_fe_pkg SHALL hold:
- register offset constants k0..k6;
- MUX bit positions;
- the per-channel stride constants 8 and 2.
REQ-038 A sub-module db_fe_chan SHALL contain one channel's shadow/active registers, datapath, counters and readback words; the top instantiates it NUM_CHANS times and muxes readback.

Verification
REQ-039 Offset saturation: NUM_CHANS=2, write ch1 RX_OFS_I=16'h7000, drive I=16'h2000 with strobe -> after 2 cycles rx_data_out ch1 I=16'h7FFF and RX sat count=1.
REQ-040 Timed apply: APPLY_MODE=1, write TX_OFS_Q=16'h0010, keep Q=0 -> Q stays 0 until the cycle after time_sync, then Q=16'h0010 two cycles later.
REQ-041 Mux/negate: MUX=4'b0011, input I=16'h0005, Q=16'h8000 -> output I=16'h7FFF (negated Q, saturated) and Q=16'h0005.
REQ-042 Readback: set rb_addr=RB_BASE+3 after 5 clipped RX samples on ch1 -> next cycle rb_stb=1 and rb_data[31:0]=5; a k6 write then a re-read gives 0.
REQ-043 Gating and reset: rx_running=0 -> rx_stb_out=0; assert reset mid-burst -> all outputs 0 and rb_data=0, registers back to pass-through.
